ft245_bus_arbiter: RTL
======================

FT245_BUS_ARBITER -- requirements
Module: ft245_bus_arbiter

Interface
REQ-001 SHALL have parameter RX_BURST_MAX, default 0, meaning max RX words per grant (0 = unlimited).
REQ-002 SHALL have parameter TX_BURST_MAX, default 0, meaning max TX words per grant (0 = unlimited).
REQ-003 SHALL have parameter TURNAROUND, default 1, meaning bus-idle cycles after every burst (legal range 1..15).
REQ-004 SHALL have parameter TX_BACKOFF_TIMEOUT, default 64, meaning idle cycles before a below-threshold non-empty TX FIFO is forced out.
REQ-005 ft_clk  in  1  FT245 bus clock; all logic rises on it.
REQ-006 ft_rst  in  1  reset, asynchronous, active-low.
REQ-007 ft_rxfn  in  1  FT245 RXF#, low = host data available.
REQ-008 ft_txen  in  1  FT245 TXE#, low = host can accept data.
REQ-009 rx_space_ok  in  1  RX FIFO free space >= start threshold.
REQ-010 rx_almost_full  in  1  RX FIFO has <= 2 free slots.
REQ-011 tx_data_ok  in  1  TX FIFO level >= start threshold.
REQ-012 tx_empty  in  1  TX FIFO empty.
REQ-013 ft_oen  out  1  FT245 OE#.
REQ-014 ft_rdn  out  1  FT245 RD#.
REQ-015 ft_wrn  out  1  FT245 WR#.
REQ-016 rx_push  out  1  one RX word is captured into the RX FIFO this edge.
REQ-017 tx_pop  out  1  one TX word is consumed from the TX FIFO this edge.
REQ-018 grant  out  2  00 none, 01 RX, 10 TX.

Function
REQ-019 States SHALL be IDLE, RX_OE, RX_RD, TX_WR, TURN.
REQ-020 rx_req SHALL be !ft_rxfn && rx_space_ok.
REQ-021 tx_req SHALL be !ft_txen && !tx_empty && (tx_data_ok || backoff_expired).
REQ-022 The backoff counter SHALL increment in IDLE while !tx_empty && !tx_data_ok, saturate at TX_BACKOFF_TIMEOUT (backoff_expired = 1), and clear on entry to TX_WR or when tx_empty.
REQ-023 IDLE SHALL go to RX_OE on rx_req only, to TX_WR on tx_req only, and on both to the direction not granted last (last_dir reset = TX, so RX wins first).
REQ-024 RX_OE SHALL last exactly 1 cycle (ft_oen=0, ft_rdn=1), then go to RX_RD.
REQ-025 RX_RD SHALL drive ft_oen=0, ft_rdn=0; rx_push = (state==RX_RD) && !ft_rxfn, combinational.
REQ-026 RX_RD SHALL exit to TURN at the edge where ft_rxfn==1, rx_almost_full==1, or (RX_BURST_MAX!=0 and the push count, including the current push, reaches RX_BURST_MAX).
REQ-027 TX_WR SHALL drive ft_wrn = !(state==TX_WR && !tx_empty), combinational; tx_pop = (state==TX_WR) && !ft_txen && !tx_empty.
REQ-028 TX_WR SHALL exit to TURN at the edge where ft_txen==1, tx_empty==1, or (TX_BURST_MAX!=0 and the pop count, including the current pop, reaches TX_BURST_MAX).
REQ-029 TURN SHALL drive ft_oen=ft_rdn=ft_wrn=1 for exactly TURNAROUND cycles, then go to IDLE.
REQ-030 Burst counters SHALL be 16 bits, cleared on grant, with no wrap inside a grant when BURST_MAX is nonzero.
REQ-031 grant SHALL be 01 in RX_OE/RX_RD, 10 in TX_WR, and 00 otherwise; last_dir SHALL update on entry to RX_OE or TX_WR.
REQ-032 rx_push and tx_pop SHALL never be high in the same cycle; ft_oen=0 and ft_wrn=0 SHALL never coincide.

Reset
REQ-033 While ft_rst=0: state=IDLE, ft_oen=ft_rdn=ft_wrn=1, rx_push=tx_pop=0, grant=00, counters=0, last_dir=TX.
REQ-034 Reset asserted mid-burst SHALL force the outputs above asynchronously; after release the first grant SHALL occur no earlier than the second ft_clk edge.

Verification
REQ-035 ft_rxfn low for 5 words, rx_space_ok=1 -> oen low 1 cycle before rdn; exactly 5 rx_push; TURN; IDLE.
REQ-036 Both requests pending continuously with TX/RX_BURST_MAX=4 -> grants alternate RX, TX, RX, ...; 4 words each; TURNAROUND idle cycles between bursts.
REQ-037 TX FIFO holds 3 words, tx_data_ok=0, ft_txen low -> TX_WR entered after exactly 64 IDLE cycles; 3 tx_pop; exit on tx_empty.
REQ-038 ft_txen rises mid-burst -> tx_pop drops the same cycle; TURN the next cycle; burst resumes after IDLE.
REQ-039 rx_almost_full asserts during RX_RD -> at most 1 further rx_push; RX FIFO never overflows.
REQ-040 ft_rst pulsed low during RX_RD -> ft_oen/ft_rdn high immediately; no rx_push; grant=00.

Source files
------------

// File: rtl/ft245_bus_arbiter.sv
// FT245 synchronous-FIFO bus arbiter.
// Shares the half-duplex FT245 data bus between the host->device (RX) and
// device->host (TX) directions. A burst runs until the host or the local
// FIFO runs dry or the optional per-grant word limit is reached. Every burst
// is followed by a fixed bus-idle turnaround. A TX FIFO that stays below its
// start threshold is forced out after a backoff period so that short
// messages are not stranded.
module ft245_bus_arbiter #(
   parameter int unsigned RX_BURST_MAX       = 0,   // 0 = unlimited
   parameter int unsigned TX_BURST_MAX       = 0,   // 0 = unlimited
   parameter int unsigned TURNAROUND         = 1,   // 1..15 idle cycles
   parameter int unsigned TX_BACKOFF_TIMEOUT = 64
) (
   input  logic       ft_clk,
   input  logic       ft_rst,          // async, active low
   input  logic       ft_rxfn,         // low = host has data for us
   input  logic       ft_txen,         // low = host can take data
   input  logic       rx_space_ok,     // RX FIFO free space >= start threshold
   input  logic       rx_almost_full,  // RX FIFO has <= 2 free slots
   input  logic       tx_data_ok,      // TX FIFO level >= start threshold
   input  logic       tx_empty,        // TX FIFO empty
   output logic       ft_oen,
   output logic       ft_rdn,
   output logic       ft_wrn,
   output logic       rx_push,
   output logic       tx_pop,
   output logic [1:0] grant
);

   // Backoff counter must be able to hold TX_BACKOFF_TIMEOUT itself.
   localparam int unsigned BO_W =
      (TX_BACKOFF_TIMEOUT < 1) ? 1 : $clog2(TX_BACKOFF_TIMEOUT + 1);
   localparam logic [BO_W-1:0] BO_MAX  = BO_W'(TX_BACKOFF_TIMEOUT);
   localparam logic [15:0]     RX_MAX  = 16'(RX_BURST_MAX);
   localparam logic [15:0]     TX_MAX  = 16'(TX_BURST_MAX);
   localparam logic [3:0]      TURN_LD = 4'(TURNAROUND - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RX_OE = 3'd1,
      RX_RD = 3'd2,
      TX_WR = 3'd3,
      TURN  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              last_tx_q, last_tx_d;   // 1 = last grant was TX
   logic              rst_done_q;             // holds off grants for one edge after reset
   logic [BO_W-1:0]   bo_q, bo_d;
   logic [15:0]       bcnt_q, bcnt_d;         // words moved in the current grant
   logic [3:0]        turn_q, turn_d;
   logic              oen_q, rdn_q;
   logic [1:0]        grant_q;

   logic              rx_req, tx_req;
   logic              bo_inc, backoff_expired;
   logic [15:0]       bcnt_inc;
   logic              rx_limit, tx_limit;

   // Request qualification and the combinational bus strobes.
   always_comb begin
      bo_inc   = (state_q == IDLE) && !tx_empty && !tx_data_ok;
      // Expiry looks one increment ahead so that the grant edge is the
      // edge that closes the TIMEOUT-th idle cycle.
      backoff_expired = (bo_q == BO_MAX) ||
                        (bo_inc && (bo_q == BO_MAX - 1'b1));
      rx_req   = !ft_rxfn && rx_space_ok;
      tx_req   = !ft_txen && !tx_empty && (tx_data_ok || backoff_expired);
      rx_push  = (state_q == RX_RD) && !ft_rxfn;
      tx_pop   = (state_q == TX_WR) && !ft_txen && !tx_empty;
      ft_wrn   = !((state_q == TX_WR) && !tx_empty);
      bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
      // Limit counts the word moving on this edge.
      rx_limit = (RX_BURST_MAX != 0) && (bcnt_q + 16'd1 >= RX_MAX);
      tx_limit = (TX_BURST_MAX != 0) && (bcnt_q + 16'd1 >= TX_MAX);
   end

   // Next-state logic for the arbiter FSM, burst, backoff and turnaround counters.
   always_comb begin
      state_d   = state_q;
      last_tx_d = last_tx_q;
      bcnt_d    = bcnt_q;
      turn_d    = turn_q;
      bo_d      = bo_q;

      if (tx_empty)
         bo_d = '0;
      else if (bo_inc && (bo_q != BO_MAX))
         bo_d = bo_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (rst_done_q) begin
               // On a tie the direction not served last wins.
               if (rx_req && (!tx_req || last_tx_q)) begin
                  state_d   = RX_OE;
                  last_tx_d = 1'b0;
                  bcnt_d    = '0;
               end else if (tx_req) begin
                  state_d   = TX_WR;
                  last_tx_d = 1'b1;
                  bcnt_d    = '0;
                  bo_d      = '0;
               end
            end
         end
         RX_OE: begin
            // One cycle of OE# alone lets the FT245 turn its data drivers on.
            state_d = RX_RD;
         end
         RX_RD: begin
            if (rx_push)
               bcnt_d = bcnt_inc;
            if (ft_rxfn || rx_almost_full || (rx_push && rx_limit)) begin
               state_d = TURN;
               turn_d  = TURN_LD;
            end
         end
         TX_WR: begin
            if (tx_pop)
               bcnt_d = bcnt_inc;
            if (ft_txen || tx_empty || (tx_pop && tx_limit)) begin
               state_d = TURN;
               turn_d  = TURN_LD;
            end
         end
         TURN: begin
            if (turn_q == 4'd0)
               state_d = IDLE;
            else
               turn_d = turn_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; OE#, RD# and grant are registered from the next state.
   always_ff @(posedge ft_clk or negedge ft_rst) begin
      if (!ft_rst) begin
         state_q    <= IDLE;
         last_tx_q  <= 1'b1;
         rst_done_q <= 1'b0;
         bo_q       <= '0;
         bcnt_q     <= '0;
         turn_q     <= '0;
         oen_q      <= 1'b1;
         rdn_q      <= 1'b1;
         grant_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         last_tx_q  <= last_tx_d;
         rst_done_q <= 1'b1;
         bo_q       <= bo_d;
         bcnt_q     <= bcnt_d;
         turn_q     <= turn_d;
         oen_q      <= !((state_d == RX_OE) || (state_d == RX_RD));
         rdn_q      <= !(state_d == RX_RD);
         grant_q    <= ((state_d == RX_OE) || (state_d == RX_RD)) ? 2'b01 :
                       (state_d == TX_WR)                          ? 2'b10 : 2'b00;
      end
   end

   assign ft_oen = oen_q;
   assign ft_rdn = rdn_q;
   assign grant  = grant_q;

endmodule
